// File: rtl/rr_mux_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
// Holds the output-slot FSM states and the source identifiers.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage

// File: rtl/mux2x1_sel.sv
// Two-input data select used to pick the granted payload.
// sel=0 passes in0, sel=1 passes in1.
module mux2x1_sel #(
    parameter int WIDTH = 64
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester arbiter feeding a single registered output slot.
// Round-robin or fixed A priority, full throughput on drain+refill.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 fixed_pri,
    input  logic                 a_valid,
    input  logic [DATAWIDTH-1:0] a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [DATAWIDTH-1:0] b_data,
    output logic                 b_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic                 d_src,
    output logic [7:0]           grant_cnt
);

    state_t               state;
    src_t                 last_grant;
    src_t                 src_q;
    src_t                 grant;
    logic                 slot_free;
    logic                 xfer;
    logic [DATAWIDTH-1:0] sel_data;

    // Slot accepts when empty or being drained; never while in reset.
    assign slot_free = Rst_n && ((state == EMPTY) || d_ready);

    // Pick a winner from the valids; only matters when both request.
    always_comb begin
        grant = SRC_A;
        if (a_valid && b_valid) begin
            if (fixed_pri)
                grant = SRC_A;
            else if (last_grant == SRC_A)
                grant = SRC_B;
            else
                grant = SRC_A;
        end else if (b_valid) begin
            grant = SRC_B;
        end
    end

    assign a_ready = slot_free && a_valid && (grant == SRC_A);
    assign b_ready = slot_free && b_valid && (grant == SRC_B);
    assign xfer    = a_ready || b_ready;

    mux2x1_sel #(
        .WIDTH(DATAWIDTH)
    ) u_sel (
        .sel(grant == SRC_B),
        .in0(a_data),
        .in1(b_data),
        .y  (sel_data)
    );

    // Output slot FSM with registered word, source and grant bookkeeping.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= EMPTY;
            d          <= '0;
            src_q      <= SRC_A;
            last_grant <= SRC_A;
            grant_cnt  <= 8'd0;
        end else begin
            if (xfer) begin
                state      <= FULL;
                d          <= sel_data;
                src_q      <= grant;
                last_grant <= grant;
                grant_cnt  <= grant_cnt + 8'd1;
            end else if ((state == FULL) && d_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign d_valid = (state == FULL);
    assign d_src   = (src_q == SRC_B);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed-vector bench for rr_mux_arbiter.
// Table of per-cycle stimulus plus reset and wrap sequences.
module tb_rr_mux_arbiter;

    localparam int W = 64;

    logic         Clk;
    logic         Rst_n;
    logic         fixed_pri;
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic [W-1:0] d;
    logic         d_valid;
    logic         d_ready;
    logic         d_src;
    logic [7:0]   grant_cnt;

    int checks;
    int errors;

    rr_mux_arbiter #(
        .DATAWIDTH(W)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .fixed_pri(fixed_pri),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_src    (d_src),
        .grant_cnt(grant_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic         fp;
        logic         av;
        logic [W-1:0] ad;
        logic         bv;
        logic [W-1:0] bd;
        logic         dr;
        logic         ar_e;
        logic         br_e;
        logic         dv_e;
        logic [W-1:0] d_e;
        logic         src_e;
        logic [7:0]   cnt_e;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic fp, input logic av, input logic [W-1:0] ad,
        input logic bv, input logic [W-1:0] bd, input logic dr,
        input logic ar_e, input logic br_e, input logic dv_e,
        input logic [W-1:0] d_e, input logic src_e,
        input logic [7:0] cnt_e);
        vec_t v;
        v.fp = fp; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
        v.dr = dr; v.ar_e = ar_e; v.br_e = br_e; v.dv_e = dv_e;
        v.d_e = d_e; v.src_e = src_e; v.cnt_e = cnt_e;
        return v;
    endfunction

    task automatic drive(input logic fp, input logic av,
                         input logic [W-1:0] ad, input logic bv,
                         input logic [W-1:0] bd, input logic dr);
        fixed_pri = fp;
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        d_ready   = dr;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // round-robin, last_grant=A after reset so B goes first
        vt[0]  = mk(0,1,64'h1,1,64'h2,1, 0,1, 1,64'h2,1,8'd1);
        vt[1]  = mk(0,1,64'h1,1,64'h2,1, 1,0, 1,64'h1,0,8'd2);
        vt[2]  = mk(0,1,64'h1,1,64'h2,1, 0,1, 1,64'h2,1,8'd3);
        vt[3]  = mk(0,1,64'h1,1,64'h2,1, 1,0, 1,64'h1,0,8'd4);
        // fixed priority: A every cycle
        vt[4]  = mk(1,1,64'h11,1,64'h20,1, 1,0, 1,64'h11,0,8'd5);
        vt[5]  = mk(1,1,64'h12,1,64'h21,1, 1,0, 1,64'h12,0,8'd6);
        vt[6]  = mk(1,1,64'h13,1,64'h22,1, 1,0, 1,64'h13,0,8'd7);
        vt[7]  = mk(1,1,64'h14,1,64'h23,1, 1,0, 1,64'h14,0,8'd8);
        // load 0x55 then backpressure three cycles
        vt[8]  = mk(0,1,64'h55,0,64'h0,1, 1,0, 1,64'h55,0,8'd9);
        vt[9]  = mk(0,1,64'h66,1,64'h77,0, 0,0, 1,64'h55,0,8'd9);
        vt[10] = mk(1,1,64'h66,1,64'h77,0, 0,0, 1,64'h55,0,8'd9);
        vt[11] = mk(0,1,64'h66,1,64'h77,0, 0,0, 1,64'h55,0,8'd9);
        // release: last was A, so B wins
        vt[12] = mk(0,1,64'h66,1,64'h77,1, 0,1, 1,64'h77,1,8'd10);
        // drain with no input, d keeps old value
        vt[13] = mk(0,0,64'h0,0,64'h0,1, 0,0, 0,64'h77,1,8'd10);
        // empty slot accepts even with d_ready low
        vt[14] = mk(0,0,64'h0,1,64'h88,0, 0,1, 1,64'h88,1,8'd11);
        // drain and refill same cycle
        vt[15] = mk(0,1,64'h99,0,64'h0,1, 1,0, 1,64'h99,0,8'd12);
        // only B valid under fixed priority still granted
        vt[16] = mk(1,0,64'h0,1,64'hAB,1, 0,1, 1,64'hAB,1,8'd13);
        vt[17] = mk(0,0,64'h0,0,64'h0,1, 0,0, 0,64'hAB,1,8'd13);
        // last was B, so A wins; leaves FULL with 0xAA
        vt[18] = mk(0,1,64'hAA,1,64'hBB,0, 1,0, 1,64'hAA,0,8'd14);

        drive(0, 0, '0, 0, '0, 0);
        Rst_n = 1'b0;
        #1;
        check("rst_ready_a", {63'd0, a_ready}, 64'd0);
        repeat (2) @(posedge Clk);
        #2;
        check("rst_d", d, 64'd0);
        check("rst_d_valid", {63'd0, d_valid}, 64'd0);
        check("rst_d_src", {63'd0, d_src}, 64'd0);
        check("rst_cnt", {56'd0, grant_cnt}, 64'd0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].fp, vt[i].av, vt[i].ad, vt[i].bv, vt[i].bd, vt[i].dr);
            #3;
            check($sformatf("v%0d_a_ready", i), {63'd0, a_ready}, {63'd0, vt[i].ar_e});
            check($sformatf("v%0d_b_ready", i), {63'd0, b_ready}, {63'd0, vt[i].br_e});
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_d_valid", i), {63'd0, d_valid}, {63'd0, vt[i].dv_e});
            check($sformatf("v%0d_d", i), d, vt[i].d_e);
            check($sformatf("v%0d_d_src", i), {63'd0, d_src}, {63'd0, vt[i].src_e});
            check($sformatf("v%0d_cnt", i), {56'd0, grant_cnt}, {56'd0, vt[i].cnt_e});
        end

        // async reset while FULL with d=0xAA, away from any edge
        drive(0, 1, 64'hC1, 1, 64'hC2, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("arst_d", d, 64'd0);
        check("arst_d_valid", {63'd0, d_valid}, 64'd0);
        check("arst_d_src", {63'd0, d_src}, 64'd0);
        check("arst_cnt", {56'd0, grant_cnt}, 64'd0);
        check("arst_a_ready", {63'd0, a_ready}, 64'd0);
        check("arst_b_ready", {63'd0, b_ready}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("rel_b_ready", {63'd0, b_ready}, 64'd1);
        @(posedge Clk);
        #1;
        check("rel_d", d, 64'hC2);
        check("rel_d_valid", {63'd0, d_valid}, 64'd1);
        check("rel_cnt", {56'd0, grant_cnt}, 64'd1);

        // counter wrap: 255 more A words bring the count back to 0
        for (int k = 0; k < 254; k++) begin
            drive(0, 1, 64'(k), 0, '0, 1);
            @(posedge Clk);
            #1;
        end
        check("wrap_255", {56'd0, grant_cnt}, 64'd255);
        check("wrap_last_d", d, 64'd253);
        drive(0, 1, 64'hE0, 0, '0, 1);
        @(posedge Clk);
        #1;
        check("wrap_0", {56'd0, grant_cnt}, 64'd0);
        check("wrap_d", d, 64'hE0);
        check("wrap_d_valid", {63'd0, d_valid}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 64, width of every data path.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 fixed_pri  input  1  1 = requester A always wins; 0 = round-robin.
REQ-005 a_valid  input  1  requester A offers a_data.
REQ-006 a_data  input  DATAWIDTH  requester A payload.
REQ-007 a_ready  output  1  A's word is accepted this cycle.
REQ-008 b_valid  input  1  requester B offers b_data.
REQ-009 b_data  input  DATAWIDTH  requester B payload.
REQ-010 b_ready  output  1  B's word is accepted this cycle.
REQ-011 d  output  DATAWIDTH  registered output word, produced through one MUX2x1-style select.
REQ-012 d_valid  output  1  d holds a word not yet consumed.
REQ-013 d_ready  input  1  consumer accepts d this cycle.
REQ-014 d_src  output  1  source of current d: 0 = A, 1 = B.
REQ-015 grant_cnt  output  8  count of accepted input words, wraps modulo 256.

Function
REQ-016 Transfer on an input side occurs when x_valid and x_ready are both 1; on the output side when d_valid and d_ready are both 1.
REQ-017 Output slot "free" = d_valid==0, or d_valid==1 and d_ready==1 in the same cycle (pass-through drain).
REQ-018 At most one of a_ready/b_ready is 1 in any cycle; both 0 when the slot is not free.
REQ-019 a_ready, b_ready are combinational from valids, fixed_pri, last-grant state and slot-free; they do not depend on a_data/b_data.
REQ-020 Arbitration: only one valid -> that requester granted; both valid with fixed_pri=1 -> A; both valid with fixed_pri=0 -> requester other than last_grant.
REQ-021 last_grant register (reset 0 = A) updates to the granted requester on every input transfer only.
REQ-022 Latency: word accepted in cycle N appears on d with d_valid=1 in cycle N+1; d_src equals the granted requester.
REQ-023 While d_valid=1 and d_ready=0, d, d_src and d_valid hold stable and no input is accepted.
REQ-024 Output drained with no input transfer in the same cycle -> d_valid=0 next cycle; d keeps its old value.
REQ-025 Drain and new accept in the same cycle -> d_valid stays 1 and d takes the new word (full throughput, one word per cycle).
REQ-026 FSM states: EMPTY (d_valid=0) and FULL (d_valid=1). EMPTY->FULL on input transfer; FULL->EMPTY on drain without input transfer; otherwise hold.
REQ-027 grant_cnt increments by 1 on each input transfer; 255 -> 0.
REQ-028 fixed_pri may change any cycle; it affects only arbitration in that cycle, never a held d.

Reset
REQ-029 Rst_n low asynchronously forces: d=0, d_valid=0, d_src=0, grant_cnt=0, last_grant=A, FSM=EMPTY.
REQ-030 While Rst_n is low, a_ready=0 and b_ready=0.
REQ-031 Reset asserted mid-transfer discards the held word; first accept after release is possible in the first Clk edge with Rst_n high.

Structure
REQ-032 Shared package holds FSM state encoding (EMPTY=0, FULL=1) and source encoding (SRC_A=0, SRC_B=1).
REQ-033 Data select is one sub-module instance, mux2x1_sel, of width DATAWIDTH, select driven by the grant; arbiter, FSM and counters stay in rr_mux_arbiter.

Verification
REQ-034 Reset: Rst_n low mid-FULL with d=0xAA -> d=0, d_valid=0, grant_cnt=0 immediately, no Clk edge needed.
REQ-035 Round-robin: fixed_pri=0, both valid continuously, d_ready=1, a_data=0x1, b_data=0x2 -> d sequence 0x2,0x1,0x2,0x1 (last_grant=A after reset), d_src alternating 1,0,1,0.
REQ-036 Fixed priority: fixed_pri=1, both valid 4 cycles, d_ready=1 -> four A words, b_ready never 1.
REQ-037 Backpressure: d_ready=0 for 3 cycles with d=0x55 held -> d, d_src stable, a_ready=b_ready=0; d_ready=1 -> next word appears next cycle.
REQ-038 Drain-and-refill: FULL, d_ready=1 and a_valid=1 same cycle -> d_valid remains 1, d=a_data next cycle, grant_cnt+1.
REQ-039 Counter wrap: 256 accepted words -> grant_cnt returns to 0.
